mem_bus_unit: RTL
=================

# mem_bus_unit

Parametrised memory interface unit that replaces the processor's hard-tied RAM strobes (cs/we/oe constant, address 0) with a real request/response engine. It sits between the state machine and external RAM and owns the instruction register and memory read data register. It sequences fetch, load and store cycles with programmable wait states, a ready handshake and an optional timeout. Byte/halfword/word lane steering and sign extension are done inside the block.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, RAM data width; power of two, ≥32; LANES = DATA_W/8, LB = log2(LANES)
- WAIT_STATES, 1, minimum cycles ram_cs is held before ram_ready is sampled
- TIMEOUT, 0, maximum access cycles before abort; 0 disables

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_kind  in  2  00 fetch, 01 load, 10 store, 11 reserved (treated as load)
- req_size  in  2  00 byte, 01 half, 10 word; ignored for fetch (always word)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- ir  out  32  instruction register, written by fetch
- mrdr  out  32  memory read data register, written by load
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misalignment or timeout
- ram_cs, ram_we, ram_oe  out  1 each  RAM strobes
- ram_address  out  ADDR_W  req_addr with low LB bits cleared
- ram_byte_en  out  LANES  active lanes for store (all ones for reads)
- ram_data_in  out  DATA_W  write data to RAM
- ram_data_out  in  DATA_W  read data from RAM
- ram_ready  in  1  RAM completion

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: req_ready=1. On req_valid, latch kind/size/signed/addr/wdata; aligned request → ACCESS; misaligned (half with addr[0]=1, word/fetch with addr[1:0]≠0) → DONE with err=1, no RAM strobes.
- ACCESS: ram_cs=1; ram_oe=1 for fetch/load; ram_we=1 for store. Cycle counter starts at 0. Access ends at first cycle with count ≥ WAIT_STATES and ram_ready=1 → DONE. If TIMEOUT≠0 and count reaches TIMEOUT−1 without ending → DONE with err=1, no register update.
- On successful end edge: fetch writes ir ← lane word at addr[LB-1:2]; load writes mrdr ← extracted byte/half/word, zero- or sign-extended per req_signed; store writes nothing.
- Lane rules (little-endian): byte k occupies ram_data bits [8k+7:8k], k = addr[LB-1:0]. Store replicates req_wdata byte/half/word across all lanes; ram_byte_en sets 1/2/4 bits starting at lane k.
- DONE: done=1 one cycle, err as determined; → IDLE. New request accepted the following cycle.
- Reset: all outputs 0 immediately (strobes, done, err, req_ready, ir, mrdr, ram_address, ram_byte_en, ram_data_in); state IDLE. Reset mid-access aborts with no register update.

## Timing
- Request accepted at edge 0 → ram_cs high cycles 1..1+WAIT_STATES (minimum), done in cycle 2+WAIT_STATES; ir/mrdr valid in the same cycle as done.
- Misaligned: done/err in cycle 1, ram_cs never asserted.
- ram_ready ignored outside ACCESS and before count reaches WAIT_STATES.
- Address, byte_en and write data held stable for the whole ACCESS state.
- req_valid ignored while req_ready=0; requester must hold it until accepted.

## Structure
- Package arm_mem_pkg: req_kind and req_size encodings, state enum, lane-count function.
- Sub-module mem_lane_align: combinational read extraction/sign-extension and write replication/byte-enable generation, parametrised on DATA_W.
- mem_bus_unit holds the FSM, counter, request latches, ir and mrdr.

## Test plan
- WAIT_STATES=1, ram_ready tied 1, fetch 0x100 returning 0xE3A01005 → cs high 2 cycles, ir=0xE3A01005, done at cycle 3, err=0.
- Signed byte load addr 0x203, ram_data_out=0x80FF0011 → mrdr=0xFFFFFF80; unsigned → 0x00000080.
- Halfword store 0x0000BEEF to 0x302 → ram_byte_en=1100, ram_data_in=0xBEEFBEEF, we=1, oe=0.
- Word load at 0x401 → done+err in cycle 1, no cs, mrdr unchanged.
- TIMEOUT=8, ram_ready held 0 → done+err after 8 access cycles; ram_ready delayed to 5th access cycle → success, done at cycle 6.
- DATA_W=64, load word at 0x104 → data from bits [63:32]; assert rst low mid-ACCESS → strobes drop immediately, ir=mrdr=0.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared encodings for the memory bus unit: request kinds/sizes, FSM states
// and lane geometry helpers.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        KindFetch = 2'b00,
        KindLoad  = 2'b01,
        KindStore = 2'b10,
        KindRsvd  = 2'b11
    } req_kind_e;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } req_size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StDone   = 2'b10
    } state_e;

    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned lane_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_bus_unit_if.sv
// Request/response and external RAM signals of the memory bus unit.
// slave is the unit itself; master is the sequencer plus RAM around it.
interface mem_bus_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_kind;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_wdata;
    logic [31:0]           ir;
    logic [31:0]           mrdr;
    logic                  done;
    logic                  err;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;
    logic [ADDR_W-1:0]     ram_address;
    logic [DATA_W/8-1:0]   ram_byte_en;
    logic [DATA_W-1:0]     ram_data_in;
    logic [DATA_W-1:0]     ram_data_out;
    logic                  ram_ready;

    modport master (
        output req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
        output ram_data_out, ram_ready,
        input  req_ready, ir, mrdr, done, err,
        input  ram_cs, ram_we, ram_oe, ram_address, ram_byte_en, ram_data_in
    );

    modport slave (
        input  req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
        input  ram_data_out, ram_ready,
        output req_ready, ir, mrdr, done, err,
        output ram_cs, ram_we, ram_oe, ram_address, ram_byte_en, ram_data_in
    );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: read extraction with sign extension, and store
// data replication with byte-enable generation.
module mem_lane_align
    import arm_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [lane_bits(DATA_W)-1:0]  wr_lane,
    input  req_size_e                     wr_size,
    input  logic                          wr_read,
    input  logic [31:0]                   wr_data,
    output logic [lane_count(DATA_W)-1:0] byte_en,
    output logic [DATA_W-1:0]             data_rep,
    input  logic [lane_bits(DATA_W)-1:0]  rd_lane,
    input  req_size_e                     rd_size,
    input  logic                          rd_signed,
    input  logic [DATA_W-1:0]             rd_data,
    output logic [31:0]                   rd_word,
    output logic [31:0]                   rd_result
);
    localparam int unsigned LANES = lane_count(DATA_W);
    localparam int unsigned LB    = lane_bits(DATA_W);

    logic [LB-1:0]    word_lane;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [LANES-1:0] be_base;

    always_comb begin
        word_lane       = rd_lane;
        word_lane[1:0]  = 2'b00;
        rd_byte         = rd_data[{rd_lane, 3'b000} +: 8];
        rd_half         = rd_data[{rd_lane, 3'b000} +: 16];
        rd_word         = rd_data[{word_lane, 3'b000} +: 32];
        rd_result       = rd_word;
        unique case (rd_size)
            SizeByte: rd_result = {{24{rd_signed & rd_byte[7]}}, rd_byte};
            SizeHalf: rd_result = {{16{rd_signed & rd_half[15]}}, rd_half};
            default:  rd_result = rd_word;
        endcase
    end

    always_comb begin
        data_rep = {(LANES / 4){wr_data}};
        be_base  = LANES'(4'b1111);
        unique case (wr_size)
            SizeByte: begin
                data_rep = {LANES{wr_data[7:0]}};
                be_base  = LANES'(4'b0001);
            end
            SizeHalf: begin
                data_rep = {(LANES / 2){wr_data[15:0]}};
                be_base  = LANES'(4'b0011);
            end
            default: begin
                data_rep = {(LANES / 4){wr_data}};
                be_base  = LANES'(4'b1111);
            end
        endcase
        byte_en = wr_read ? {LANES{1'b1}} : (be_base << wr_lane);
    end

endmodule

// File: rtl/mem_bus_unit.sv
// Memory request/response engine: sequences fetch/load/store RAM cycles with
// wait states, a ready handshake and optional timeout; owns ir and mrdr.
module mem_bus_unit
    import arm_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 0
) (
    input logic           clk,
    input logic           rst,
    mem_bus_unit_if.slave bus
);
    localparam int unsigned LANES = lane_count(DATA_W);
    localparam int unsigned LB    = lane_bits(DATA_W);

    state_e            state_q, state_d;
    logic              req_ready_q;
    req_kind_e         kind_q;
    req_size_e         size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [31:0]       cnt_q;
    logic [31:0]       ir_q;
    logic [31:0]       mrdr_q;
    logic [LANES-1:0]  be_q;
    logic [DATA_W-1:0] wdata_q;

    req_kind_e         in_kind;
    req_size_e         in_size;
    logic              misalign;
    logic              accept;
    logic              access_end;
    logic              access_tmo;
    logic [LANES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_rep;
    logic [31:0]       rd_word;
    logic [31:0]       rd_result;

    // Fetch is always a word access regardless of req_size.
    always_comb begin
        in_kind  = req_kind_e'(bus.req_kind);
        in_size  = (in_kind == KindFetch) ? SizeWord : req_size_e'(bus.req_size);
        misalign = 1'b0;
        unique case (in_size)
            SizeByte: misalign = 1'b0;
            SizeHalf: misalign = bus.req_addr[0];
            default:  misalign = |bus.req_addr[1:0];
        endcase
    end

    assign accept     = (state_q == StIdle) && req_ready_q && bus.req_valid;
    assign access_end = (state_q == StAccess) && (cnt_q >= WAIT_STATES) && bus.ram_ready;
    assign access_tmo = (state_q == StAccess) && !access_end && (TIMEOUT != 0) &&
                        (cnt_q == TIMEOUT - 1);

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .wr_lane   (bus.req_addr[LB-1:0]),
        .wr_size   (in_size),
        .wr_read   (in_kind != KindStore),
        .wr_data   (bus.req_wdata),
        .byte_en   (wr_be),
        .data_rep  (wr_rep),
        .rd_lane   (addr_q[LB-1:0]),
        .rd_size   (size_q),
        .rd_signed (signed_q),
        .rd_data   (bus.ram_data_out),
        .rd_word   (rd_word),
        .rd_result (rd_result)
    );

    // req_ready is registered so it reads 0 while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = misalign ? StDone : StAccess;
            StAccess: if (access_end || access_tmo) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ram_cs      = (state_q == StAccess);
        bus.ram_oe      = (state_q == StAccess) && (kind_q != KindStore);
        bus.ram_we      = (state_q == StAccess) && (kind_q == KindStore);
        bus.done        = (state_q == StDone);
        bus.err         = (state_q == StDone) && err_q;
        bus.req_ready   = req_ready_q;
        bus.ir          = ir_q;
        bus.mrdr        = mrdr_q;
        bus.ram_address = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
        bus.ram_byte_en = be_q;
        bus.ram_data_in = wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q   <= KindFetch;
            size_q   <= SizeByte;
            signed_q <= 1'b0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ir_q     <= '0;
            mrdr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            if (accept) begin
                kind_q   <= in_kind;
                size_q   <= in_size;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                be_q     <= wr_be;
                wdata_q  <= wr_rep;
                err_q    <= misalign;
                cnt_q    <= '0;
            end else if (state_q == StAccess) begin
                if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
                if (access_tmo) err_q <= 1'b1;
            end
            if (access_end) begin
                if (kind_q == KindFetch) begin
                    ir_q <= rd_word;
                end else if (kind_q != KindStore) begin
                    mrdr_q <= rd_result;
                end
            end
        end
    end

endmodule
